// File: rtl/hs_if.sv
// Handshake bundle between an asynchronous source, the hs_receiver and its local consumer.
`timescale 1ns/1ps
interface hs_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  async_req;
    logic [DATA_WIDTH-1:0] async_data;
    logic                  ack;
    logic                  rx_ready;
    logic                  rx_valid;
    logic [DATA_WIDTH-1:0] rx_data;

    modport master (
        output async_req,
        output async_data,
        input  ack,
        output rx_ready,
        input  rx_valid,
        input  rx_data
    );

    modport slave (
        input  async_req,
        input  async_data,
        output ack,
        input  rx_ready,
        output rx_valid,
        output rx_data
    );
endinterface

// File: rtl/hs_receiver.sv
// Receive side of a 4-phase req/ack clock-domain crossing with valid/ready delivery.
// Optional ack timeout and sticky error state enabled by defining HS_TIMEOUT_EN.
`timescale 1ns/1ps
module hs_receiver #(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       n_rst,
    hs_if.slave        bus,
    output logic       busy,
    output logic [7:0] xfer_count,
    output logic       err
);

    if (TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("hs_receiver: TIMEOUT_CYCLES must be at least 2");
    end

`ifdef HS_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, VALID, ACK, ERR} state_t;
`else
    typedef enum logic [1:0] {IDLE, VALID, ACK} state_t;
`endif

    state_t state, state_nxt;
    logic   sync_p0;
    logic   req_s;
    logic   load_data;
    logic   accept;

    // Two-flop synchronizer: the only consumer of async_req
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_p0 <= 1'b0;
            req_s   <= 1'b0;
        end else begin
            sync_p0 <= bus.async_req;
            req_s   <= sync_p0;
        end
    end

`ifdef HS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             err_q;

    // Counter sits at 0 outside ACK, so the first ACK cycle sees 0
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            tmo_cnt <= (state == ACK) ? tmo_cnt + 1'b1 : '0;
            if (state_nxt == ERR)
                err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (req_s) state_nxt = VALID;
            VALID: if (bus.rx_ready) state_nxt = ACK;
`ifdef HS_TIMEOUT_EN
            ACK: begin
                if (!req_s)
                    state_nxt = IDLE;
                else if (tmo_cnt == CNT_LAST)
                    state_nxt = ERR;
            end
            ERR:   if (!req_s) state_nxt = IDLE;
`else
            ACK:   if (!req_s) state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    assign load_data = (state == IDLE) && req_s;
    assign accept    = (state == VALID) && bus.rx_ready;

    // Data is captured only on IDLE->VALID, so it stays frozen under backpressure
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bus.rx_data <= '0;
            xfer_count  <= 8'd0;
        end else begin
            if (load_data)
                bus.rx_data <= bus.async_data;
            if (accept)
                xfer_count <= xfer_count + 8'd1;
        end
    end

    assign bus.rx_valid = (state == VALID);
    assign bus.ack      = (state == ACK);
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_hs_receiver.sv
// Directed self-checking bench for hs_receiver; covers HS_TIMEOUT_EN when it is defined.
`timescale 1ns/1ps
module tb_hs_receiver;

    logic       tb_clk = 1'b0;
    logic       n_rst;
    logic       busy;
    logic [7:0] xfer_count;
    logic       err;

    int n_cmp  = 0;
    int n_fail = 0;

    hs_if #(.DATA_WIDTH(8)) bus ();

    hs_receiver #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
        .clk        (tb_clk),
        .n_rst      (n_rst),
        .bus        (bus.slave),
        .busy       (busy),
        .xfer_count (xfer_count),
        .err        (err)
    );

    always #5 tb_clk = ~tb_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge tb_clk);
    endtask

    task automatic wait_ack(input string tag, input logic val, input int budget);
        int  i;
        bit  seen;
        seen = 1'b0;
        for (i = 0; i < budget && !seen; i++) begin
            @(negedge tb_clk);
            if (bus.ack === val) seen = 1'b1;
        end
        chk(tag, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ack_cycles;

        // Power-on reset with a request already asserted
        n_rst          = 1'b0;
        bus.async_req  = 1'b1;
        bus.async_data = 8'h5A;
        bus.rx_ready   = 1'b1;
        #1;
        chk("rst_ack", {31'd0, bus.ack}, 32'd0);
        chk("rst_valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("rst_data", {24'd0, bus.rx_data}, 32'h00);
        @(posedge tb_clk); #1;
        chk("rst_ack_edge", {31'd0, bus.ack}, 32'd0);
        chk("rst_valid_edge", {31'd0, bus.rx_valid}, 32'd0);
        chk("rst_data_edge", {24'd0, bus.rx_data}, 32'h00);
        chk("rst_count", {24'd0, xfer_count}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge tb_clk);
        bus.async_req = 1'b0;
        n_rst = 1'b1;
        step(3);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Single transfer, consumer always ready
        bus.async_data = 8'hA5;
        bus.async_req  = 1'b1;
        step(1);
        chk("st_valid_k", {31'd0, bus.rx_valid}, 32'd0);
        step(1);
        chk("st_valid_k1", {31'd0, bus.rx_valid}, 32'd0);
        step(1);
        chk("st_valid_k2", {31'd0, bus.rx_valid}, 32'd1);
        chk("st_data", {24'd0, bus.rx_data}, 32'hA5);
        chk("st_ack_early", {31'd0, bus.ack}, 32'd0);
        step(1);
        chk("st_valid_1cyc", {31'd0, bus.rx_valid}, 32'd0);
        chk("st_ack", {31'd0, bus.ack}, 32'd1);
        chk("st_count", {24'd0, xfer_count}, 32'd1);
        bus.async_req = 1'b0;
        step(1);
        chk("st_ack_n", {31'd0, bus.ack}, 32'd1);
        step(1);
        chk("st_ack_n1", {31'd0, bus.ack}, 32'd1);
        step(1);
        chk("st_ack_n2", {31'd0, bus.ack}, 32'd0);
        chk("st_busy_done", {31'd0, busy}, 32'd0);

        // Backpressure: data frozen while the consumer stalls
        bus.rx_ready   = 1'b0;
        bus.async_data = 8'h3C;
        bus.async_req  = 1'b1;
        step(3);
        chk("bp_valid", {31'd0, bus.rx_valid}, 32'd1);
        bus.async_data = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("bp_hold_valid", {31'd0, bus.rx_valid}, 32'd1);
            chk("bp_hold_data", {24'd0, bus.rx_data}, 32'h3C);
            chk("bp_hold_ack", {31'd0, bus.ack}, 32'd0);
        end
        chk("bp_count_hold", {24'd0, xfer_count}, 32'd1);
        bus.rx_ready = 1'b1;
        step(1);
        chk("bp_ack", {31'd0, bus.ack}, 32'd1);
        chk("bp_count", {24'd0, xfer_count}, 32'd2);
        bus.async_req = 1'b0;
        step(3);
        chk("bp_ack_low", {31'd0, bus.ack}, 32'd0);

        // Request edges placed just before / just after a rising clock edge
        bus.async_data = 8'h96;
        @(negedge tb_clk);
        #4.905 bus.async_req = 1'b1;
        wait_ack("sh_ack_rise", 1'b1, 20);
        chk("sh_data", {24'd0, bus.rx_data}, 32'h96);
        @(posedge tb_clk);
        #0.05 bus.async_req = 1'b0;
        wait_ack("sh_ack_fall", 1'b0, 20);
        chk("sh_count", {24'd0, xfer_count}, 32'd3);
        chk("sh_valid_known", {31'd0, $isunknown(bus.rx_valid)}, 32'd0);
        chk("sh_busy_known", {31'd0, $isunknown(busy)}, 32'd0);
        step(4);
        chk("sh_no_dup", {24'd0, xfer_count}, 32'd3);

        // Reset while in ACK, release with request still high
        bus.async_data = 8'h77;
        bus.async_req  = 1'b1;
        step(4);
        chk("rm_ack", {31'd0, bus.ack}, 32'd1);
        chk("rm_count_pre", {24'd0, xfer_count}, 32'd4);
        n_rst = 1'b0;
        #1;
        chk("rm_ack_clr", {31'd0, bus.ack}, 32'd0);
        chk("rm_count_clr", {24'd0, xfer_count}, 32'd0);
        chk("rm_data_clr", {24'd0, bus.rx_data}, 32'h00);
        @(negedge tb_clk);
        n_rst = 1'b1;
        step(3);
        chk("rm_dup_valid", {31'd0, bus.rx_valid}, 32'd1);
        chk("rm_dup_data", {24'd0, bus.rx_data}, 32'h77);
        step(1);
        chk("rm_dup_ack", {31'd0, bus.ack}, 32'd1);
        chk("rm_dup_count", {24'd0, xfer_count}, 32'd1);

        // Source keeps request high while ack is up
`ifdef HS_TIMEOUT_EN
        ack_cycles = 1;
        for (int i = 0; i < 40 && bus.ack === 1'b1; i++) begin
            step(1);
            if (bus.ack === 1'b1) ack_cycles++;
        end
        chk("to_ack_cycles", ack_cycles, 32'd16);
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_busy_err", {31'd0, busy}, 32'd1);
        bus.async_req = 1'b0;
        step(3);
        chk("to_idle", {31'd0, busy}, 32'd0);
        chk("to_err_sticky", {31'd0, err}, 32'd1);
        chk("to_ack_low", {31'd0, bus.ack}, 32'd0);
`else
        ack_cycles = 1;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (bus.ack === 1'b1) ack_cycles++;
        end
        chk("nt_ack_cycles", ack_cycles, 32'd31);
        chk("nt_err", {31'd0, err}, 32'd0);
        bus.async_req = 1'b0;
        step(3);
        chk("nt_idle", {31'd0, busy}, 32'd0);
        chk("nt_ack_low", {31'd0, bus.ack}, 32'd0);
`endif
        chk("end_count", {24'd0, xfer_count}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hs_receiver.md
# hs_receiver

- Receive side of a 4-phase req/ack handshake that brings a data word from an unrelated clock domain into the `clk` domain.
- Synchronizes the asynchronous `async_req` through an internal two-flop synchronizer.
- Captures the source's stable data bus and presents it to the local consumer with a valid/ready handshake.
- Sequences `ack` back to the source, counts completed transfers, and can flag a stuck source.

## Interface
- `DATA_WIDTH`, 8: width of transferred word.
- `TIMEOUT_CYCLES`, 16: maximum cycles `ack` stays high waiting for `req` to fall. Only used with `HS_TIMEOUT_EN`. Must be ≥ 2.
- `clk` in 1: system clock, rising-edge.
- `n_rst` in 1: asynchronous, active-low reset.
- `async_req` in 1: source request, asynchronous to `clk`, active high.
- `async_data` in `DATA_WIDTH`: source data. The source guarantees it is stable from before `async_req` rises until `ack` is seen high.
- `rx_ready` in 1: consumer can accept `rx_data` this cycle.
- `ack` out 1: acknowledge to source, registered.
- `rx_valid` out 1: `rx_data` holds an unconsumed word, registered.
- `rx_data` out `DATA_WIDTH`: captured word, registered.
- `busy` out 1: FSM is not in IDLE.
- `xfer_count` out 8: completed-transfer counter, wraps 255→0.
- `err` out 1: sticky timeout flag.

## Operation
- Synchronizer: two flops in series, both reset to 0; output is `req_s`. `async_req` feeds nothing else.
- FSM states: IDLE, VALID, ACK, and ERR (ERR exists only with `HS_TIMEOUT_EN`).
- IDLE:
  - When `req_s`=1, go to VALID and load `rx_data` <= `async_data` on that same edge.
  - Otherwise stay in IDLE.
- VALID:
  - `rx_valid`=1.
  - If `rx_ready`=1, the word is accepted: go to ACK and increment `xfer_count`.
  - Otherwise hold; `rx_data` is frozen.
- ACK:
  - `ack`=1.
  - When `req_s`=0, go to IDLE.
- Outputs are decoded from registered state only. No combinational path from any input to any output.
  - `rx_valid` = (state==VALID).
  - `ack` = (state==ACK).
  - `busy` = (state!=IDLE).
- `rx_data` changes only on an IDLE→VALID transition.
- Back-to-back transfers: if `req_s` is already 1 in IDLE, a new transfer starts. A compliant source cannot cause this, because it waits for `ack` low.
- Reset values: state IDLE, `ack`=0, `rx_valid`=0, `busy`=0, `rx_data`=0, `xfer_count`=0, `err`=0, synchronizer flops 0.
- Reset mid-transfer: everything clears immediately. If `async_req` is still high after reset is released, the word is captured again (duplicate delivery). This is accepted behaviour.
- `async_req`=X: the synchronizer may resolve to either value. The FSM must never hold X state; the X must not propagate past the second flop's decayed output into the state register. The bench checks this.

## Timing
- `async_req` rising, sampled by flop 1 at edge k:
  - `req_s`=1 after edge k+1.
  - VALID after edge k+2, i.e. `rx_valid` rises 2 edges after first capture.
- `rx_ready`=1 in VALID at edge m: `ack`=1 after edge m, and `xfer_count` updates at edge m.
- With `rx_ready` held high, `rx_valid` is high for exactly one cycle.
- `async_req` falling, sampled at edge n: `ack`=0 after edge n+2.
- Minimum full transfer with `rx_ready`=1 and an immediate source response: about 6 `clk` cycles plus source-side latency.

## Configuration
- `HS_TIMEOUT_EN` defined:
  - A cycle counter clears on entry to ACK and increments each cycle in ACK.
  - If `req_s`=1 when the count reaches `TIMEOUT_CYCLES`−1, go to ERR and set `err`=1, so `ack` is high for at most `TIMEOUT_CYCLES` cycles.
  - In ERR: `ack`=0, `busy`=1. Go to IDLE when `req_s`=0.
  - `err` stays set until reset.
- `HS_TIMEOUT_EN` not defined:
  - No counter and no ERR state; `err` is tied to 0.
  - ACK waits indefinitely.

## Test plan
- Power-on reset: `n_rst`=0 with `async_req`=1 → `ack`=0, `rx_valid`=0, `rx_data`=0x00, `xfer_count`=0, `err`=0, both before and after a clock edge.
- Single transfer: `async_data`=0xA5, raise `async_req` at a negedge, `rx_ready`=1 → `rx_valid` high for 1 cycle 2 edges later with `rx_data`=0xA5; `ack`=1 the next cycle; drop `async_req` → `ack`=0 2 edges later; `xfer_count`=1.
- Backpressure: `rx_ready`=0 for 5 cycles with `async_data`=0x3C, then changed to 0xFF while `rx_valid` is high → `rx_valid` held 5+ cycles, `rx_data` stays 0x3C, `ack` stays 0 until `rx_ready`=1.
- Setup/hold violations: toggle `async_req` 0.095 ns before and 0.05 ns after a rising edge → `req_s` resolves to 0 or 1, never X. Exactly one transfer per request; `xfer_count` increments once.
- Reset mid-ACK, then release with `async_req`=1 → duplicate delivery of the same word; `xfer_count` goes 0→1.
- With `HS_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, `async_req` held high → `ack` high exactly 16 cycles, then `err`=1 and `ack`=0. Drop `async_req` → IDLE; `err` stays 1.
